reg_file_sweep: RTL
===================

// Module: reg_file_sweep
// PURPOSE
//   Parametrised successor to the SCC-Unix register file, sitting between ID and EXE.
//   Adds per-write merge modes for MOV/MOVT/SET/CLR and same-cycle read bypass.
//   Adds a sequential clear sweep that zeroes the array one register per cycle,
//   after reset or on request, so the array can map onto single-port RAM.
// PARAMETERS
//   DATA_W    32   register width; must be even (half = DATA_W/2)
//   NUM_REGS  8    number of architectural registers (>=2)
//   ADDR_W    $clog2(NUM_REGS)  register address width (derived, localparam)
//   NUM_RD    2    number of combinational read ports
//   BYPASS    1    1: a read of the register being written returns the merged new value
// PORTS
//   clk          in   1              system clock, all state updates on posedge
//   rst          in   1              synchronous reset, active-high
//   rd_addr      in   NUM_RD*ADDR_W  packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data      out  NUM_RD*DATA_W  packed read data, port p at [p*DATA_W +: DATA_W]
//   wr_en        in   1              write request this cycle
//   wr_addr      in   ADDR_W         destination register
//   wr_mode      in   3              0 FULL, 1 LO_ZX, 2 HI_KEEP, 3 SET, 4 CLR, 5-7 reserved
//   wr_data_id   in   DATA_W         immediate value from ID
//   wr_data_exe  in   DATA_W         result from EXE
//   wr_data_sel  in   1              0: source = wr_data_id; 1: source = wr_data_exe
//   clr_all_req  in   1              single-cycle pulse that starts a clear sweep
//   ready        out  1              1: array valid, writes accepted
// BEHAVIOUR
//   State machine, states SWEEP and RUN:
//     rst=1          -> SWEEP, sweep_idx=0, ready=0; array contents are not touched by rst itself.
//     SWEEP          -> writes 0 to reg[sweep_idx] each cycle and increments sweep_idx.
//                       After reg[NUM_REGS-1] is cleared -> RUN on the next posedge.
//                       The sweep therefore takes exactly NUM_REGS cycles after rst falls.
//     RUN            -> clr_all_req=1 -> SWEEP with sweep_idx=0.
//   ready output:
//     ready = (state==RUN), registered; 0 during rst and the whole sweep.
//     ready rises on the posedge after the last register is cleared.
//   Reads:
//     Combinational (zero latency), as in the existing file.
//     rd_data is forced to 0 while ready=0.
//   Writes:
//     Committed at posedge when wr_en & ready; ignored while ready=0 (no queuing).
//     src = wr_data_sel ? wr_data_exe : wr_data_id; H = DATA_W/2; old = current reg value.
//     FULL    -> src
//     LO_ZX   -> {H'0, src[H-1:0]}                 (MOV)
//     HI_KEEP -> {src[H-1:0], old[H-1:0]}           (MOVT)
//     SET     -> all ones
//     CLR     -> all zeros
//     reserved mode -> no write; the register keeps its value.
//   Bypass: if BYPASS=1, ready=1, wr_en=1 and rd_addr[p]==wr_addr with a non-reserved mode,
//     rd_data[p] is the merged value. Otherwise reads return the stored value.
//   Simultaneous events:
//     clr_all_req together with wr_en -> the write is dropped and the sweep starts.
//     clr_all_req during SWEEP -> ignored.
//     rst mid-sweep or mid-RUN -> the sweep restarts at index 0.
//     Multiple read ports on the same address -> identical data.
//   Widths: no carries. Address values >= NUM_REGS (non-power-of-two NUM_REGS) ->
//     writes dropped, reads return 0.
// STRUCTURE
//   Package sccu_rf_pkg:
//     wr_mode_e (FULL, LO_ZX, HI_KEEP, SET, CLR)
//     rf_state_e (SWEEP, RUN)
//   Sub-module rf_write_merge (combinational): (mode, src, old) -> (new_val, valid).
//     Shared by the write path and the bypass path so the two cannot diverge.
//   Top level holds the array, the FSM, the sweep counter and the read muxes.
// TESTING (defaults: DATA_W=32, NUM_REGS=8)
//   1 Pulse rst for 1 cycle
//       -> ready=0 for exactly 8 posedges, then 1; all regs read 0x0000_0000.
//   2 LO_ZX R0 src_id=0x1234_FFFF, then HI_KEEP R0 src_id=0x0000_EEEE
//       -> R0 reads 0x0000_FFFF, then 0xEEEE_FFFF.
//   3 SET R1, then CLR R1, then FULL R2 with sel=1, exe=0xDEAD_BEEF
//       -> R1 = 0xFFFF_FFFF, then 0x0; R2 = 0xDEAD_BEEF while wr_data_id is ignored.
//   4 R3=0x5 stored; in one cycle write FULL R3=0x7 with rd_addr0=rd_addr1=3
//       -> both ports read 0x7 the same cycle (BYPASS=1), or 0x5 (BYPASS=0).
//   5 Regs loaded; clr_all_req + wr_en FULL R4=0x9 in the same cycle
//       -> R4 is not written; ready=0 for 8 cycles; all regs are 0 afterwards.
//   6 rst asserted at sweep_idx=5
//       -> sweep restarts; ready rises 8 cycles after rst falls; writes attempted while ready=0 are lost.

Source files
------------

// File: rtl/sccu_rf_pkg.sv
// Shared types for the sweep-cleared register file.
// Holds the write-merge mode encoding and the FSM state encoding.
package sccu_rf_pkg;

  typedef enum logic [2:0] {
    WM_FULL    = 3'd0,
    WM_LO_ZX   = 3'd1,
    WM_HI_KEEP = 3'd2,
    WM_SET     = 3'd3,
    WM_CLR     = 3'd4
  } wr_mode_e;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  // Codes 5..7 are reserved and never modify a register.
  function automatic logic mode_is_valid(input logic [2:0] mode);
    return mode <= WM_CLR;
  endfunction

endpackage

// File: rtl/rf_write_merge.sv
// Combinational write merge: combines the write source with the old register value.
// Used by both the commit path and the bypass path so they always agree.
module rf_write_merge
  import sccu_rf_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        mode_i,
  input  logic [DATA_W-1:0] src_i,
  input  logic [DATA_W-1:0] old_i,
  output logic [DATA_W-1:0] new_val_o,
  output logic              valid_o
);

  localparam int H = DATA_W / 2;

  always_comb begin
    new_val_o = old_i;
    valid_o   = mode_is_valid(mode_i);
    case (wr_mode_e'(mode_i))
      WM_FULL:    new_val_o = src_i;
      WM_LO_ZX:   new_val_o = {{(DATA_W-H){1'b0}}, src_i[H-1:0]};
      WM_HI_KEEP: new_val_o = {src_i[DATA_W-H-1:0], old_i[H-1:0]};
      WM_SET:     new_val_o = '1;
      WM_CLR:     new_val_o = '0;
      default:    new_val_o = old_i;
    endcase
  end

endmodule

// File: rtl/reg_file_sweep.sv
// Register file between ID and EXE with merge-mode writes, same-cycle read bypass
// and a one-register-per-cycle clear sweep after reset or on request.
module reg_file_sweep
  import sccu_rf_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 8,
  parameter  int NUM_RD   = 2,
  parameter  bit BYPASS   = 1'b1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [2:0]               wr_mode,
  input  logic [DATA_W-1:0]        wr_data_id,
  input  logic [DATA_W-1:0]        wr_data_exe,
  input  logic                     wr_data_sel,
  input  logic                     clr_all_req,
  output logic                     ready
);

  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] sweep_idx_q, sweep_idx_d;

  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  logic              wr_in_range;
  logic [DATA_W-1:0] wr_src;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_merged;
  logic              wr_valid;
  logic              wr_commit;
  logic              bypass_live;

  assign ready       = (state_q == ST_RUN);
  assign wr_in_range = {1'b0, wr_addr} < NUM_REGS_W;
  assign wr_src      = wr_data_sel ? wr_data_exe : wr_data_id;
  assign wr_old      = wr_in_range ? mem_q[wr_addr] : '0;

  rf_write_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .mode_i    (wr_mode),
    .src_i     (wr_src),
    .old_i     (wr_old),
    .new_val_o (wr_merged),
    .valid_o   (wr_valid)
  );

  // A clear request wins over a write presented in the same cycle.
  assign wr_commit   = ready && wr_en && wr_valid && wr_in_range && !clr_all_req;
  assign bypass_live = BYPASS && ready && wr_en && wr_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SWEEP;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = wr_addr;
    mem_wdata_d = wr_merged;
    case (state_q)
      ST_SWEEP: begin
        mem_we_d    = 1'b1;
        mem_waddr_d = sweep_idx_q;
        mem_wdata_d = '0;
        if (sweep_idx_q == LAST_IDX) begin
          state_d     = ST_RUN;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (clr_all_req) begin
          state_d     = ST_SWEEP;
          sweep_idx_d = '0;
        end else if (wr_commit) begin
          mem_we_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_SWEEP;
        sweep_idx_d = '0;
      end
    endcase
    // Reset only restarts the sweep; the array itself is left alone.
    if (rst) begin
      mem_we_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              in_range;
      logic              hit;
      logic [DATA_W-1:0] val;

      assign addr     = rd_addr[gi*ADDR_W +: ADDR_W];
      assign in_range = {1'b0, addr} < NUM_REGS_W;
      assign hit      = bypass_live && (addr == wr_addr);

      always_comb begin
        val = '0;
        if (ready && in_range) begin
          val = hit ? wr_merged : mem_q[addr];
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = val;
    end
  endgenerate

endmodule
